// File: rtl/bram_reader.sv
// Sequential read initiator for a synchronous lookup BRAM.
// Sweeps START_ADDR..DEPTH-1, streams words out on valid/ready and keeps an XOR checksum.
module bram_reader #(
    parameter int DEPTH      = 10,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_index;
    logic              r_valid;
    logic [DATA_W-1:0] r_sum;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [ADDR_W-1:0] w_index_nxt;
    logic              w_valid_nxt;
    logic [DATA_W-1:0] w_sum_nxt;
    logic              w_handshake;
    logic              w_last;

    assign w_handshake = r_valid & out_ready;
    assign w_last      = (r_addr == LAST_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_index_nxt = r_index;
        w_valid_nxt = r_valid;
        w_sum_nxt   = r_sum;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                    w_addr_nxt  = FIRST_ADDR;
                    w_sum_nxt   = '0;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_data_nxt  = mem_data;
                    w_index_nxt = r_addr;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // abort wins over a coincident handshake; the word is dropped
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (w_handshake) begin
                    w_sum_nxt   = r_sum ^ r_data;
                    w_valid_nxt = 1'b0;
                    if (!w_last) begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_ISSUE;
                    end else if (loop) begin
                        w_addr_nxt  = FIRST_ADDR;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_index <= w_index_nxt;
            r_valid <= w_valid_nxt;
            r_sum   <= w_sum_nxt;
        end
    end

    assign mem_addr  = r_addr;
    assign out_data  = r_data;
    assign out_index = r_index;
    assign out_valid = r_valid;
    assign checksum  = r_sum;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
